// File: rtl/pair_toggle_arbiter.sv
// Two-requester round-robin arbiter owning a complementary toggle pair (x, y).
// Define PAIR_ARB_FORMAL_EN to compile in the standalone formal property set.
module pair_toggle_arbiter #(
  parameter int CNT_W     = 3,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       step,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             x,
  output logic             y,
  output logic [CNT_W-1:0] burst_cnt,
  output logic             stray,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Handshake: req is a level held for as long as ownership is wanted; gnt
  // follows one edge later, and a step counts only when step[i] & gnt[i].
  state_t             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               x_q, x_d;
  logic               y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stray_q, stray_d;
  logic               last_q, last_d;

  logic               own;
  logic               stepped;
  logic [CNT_W-1:0]   cnt_inc;
  logic               exhaust;
  logic               release_own;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    stray_d     = |(step & ~gnt_q);
    own         = (state_q == OWN1);
    stepped     = 1'b0;
    cnt_inc     = cnt_q + CNT_W'(1);
    exhaust     = 1'b0;
    release_own = 1'b0;

    case (state_q)
      IDLE: begin
        if (req == 2'b01 || (req == 2'b11 && last_q)) begin
          state_d = OWN0;
          gnt_d   = 2'b01;
          cnt_d   = '0;
        end else if (req != 2'b00) begin
          state_d = OWN1;
          gnt_d   = 2'b10;
          cnt_d   = '0;
        end
      end
      OWN0, OWN1: begin
        stepped = step[own];
        if (stepped) begin
          x_d   = !y_q;
          y_d   = !x_q;
          cnt_d = cnt_inc;
        end
        exhaust     = stepped && (cnt_inc == CNT_W'(BURST_MAX));
        release_own = !req[own] || exhaust;
        // A step on the release cycle has already been applied above.
        if (release_own) begin
          last_d = own;
          if (req[~own]) begin
            state_d = own ? OWN0 : OWN1;
            gnt_d   = own ? 2'b01 : 2'b10;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = 2'b00;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      cnt_q   <= '0;
      stray_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      stray_q <= stray_d;
      last_q  <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = |gnt_q;
  assign x         = x_q;
  assign y         = y_q;
  assign burst_cnt = cnt_q;
  assign stray     = stray_q;
  assign dbg_state = state_q;

`ifdef PAIR_ARB_FORMAL_EN
  logic             f_past_valid = 1'b0;
  logic [CNT_W+1:0] f_wait0_q;
  logic [CNT_W+1:0] f_wait1_q;

  always @(posedge clk) f_past_valid <= 1'b1;

  always @(*) begin
    if (!f_past_valid) assume (!rst_n);
    // The fairness bound only holds while the current owner keeps stepping.
    if (gnt_q != 2'b00) assume ((step & gnt_q) != 2'b00);
    if (rst_n) begin
      assert (x_q == y_q);
      assert ($onehot0(gnt_q));
      assert (cnt_q <= CNT_W'(BURST_MAX));
      assert (busy == |gnt);
      assert (f_wait0_q <= (CNT_W+2)'(BURST_MAX + 1));
      assert (f_wait1_q <= (CNT_W+2)'(BURST_MAX + 1));
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_wait0_q <= '0;
      f_wait1_q <= '0;
    end else begin
      f_wait0_q <= (req[0] && !gnt_q[0]) ? f_wait0_q + 1'b1 : '0;
      f_wait1_q <= (req[1] && !gnt_q[1]) ? f_wait1_q + 1'b1 : '0;
    end
  end
`endif

endmodule

// File: tb/tb_pair_toggle_arbiter.sv
// Randomised bench for pair_toggle_arbiter against an ownership-level model.
module tb_pair_toggle_arbiter;
  localparam int CNT_W     = 3;
  localparam int BURST_MAX = 4;
  localparam int W         = 2 + 1 + 1 + 1 + CNT_W + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [1:0]       step = 2'b00;
  logic [1:0]       gnt;
  logic             busy;
  logic             x;
  logic             y;
  logic [CNT_W-1:0] burst_cnt;
  logic             stray;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // Model: owner is -1 when idle; pair is the shared value of x and y.
  int m_owner;
  int m_cnt;
  int m_last;
  bit m_pair;
  bit m_stray;

  pair_toggle_arbiter #(.CNT_W(CNT_W), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .step(step), .gnt(gnt),
    .busy(busy), .x(x), .y(y), .burst_cnt(burst_cnt), .stray(stray),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_vec();
    logic [1:0] g;
    g = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    return {g, (m_owner >= 0), m_pair, m_pair, CNT_W'(m_cnt), m_stray};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = 1;
    m_pair  = 1'b0;
    m_stray = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] r, input logic [1:0] s);
    int i;
    m_stray = 1'b0;
    for (int j = 0; j < 2; j++)
      if (s[j] && j != m_owner) m_stray = 1'b1;
    if (m_owner < 0) begin
      if (r == 2'b11) begin
        m_owner = 1 - m_last;
        m_cnt   = 0;
      end else if (r != 2'b00) begin
        m_owner = r[0] ? 0 : 1;
        m_cnt   = 0;
      end
    end else begin
      i = m_owner;
      if (s[i]) begin
        m_pair = !m_pair;
        m_cnt++;
      end
      if (!r[i] || (s[i] && m_cnt == BURST_MAX)) begin
        m_last = i;
        if (r[1-i]) begin
          m_owner = 1 - i;
          m_cnt   = 0;
        end else begin
          m_owner = -1;
        end
      end
    end
    exp_q.push_back(model_vec());
  endtask

  task automatic compare_outputs(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_gnt"}, gnt, e[CNT_W+5:CNT_W+4]);
    check({tag, "_busy"}, busy, e[CNT_W+3]);
    check({tag, "_x"}, x, e[CNT_W+2]);
    check({tag, "_y"}, y, e[CNT_W+1]);
    check({tag, "_cnt"}, burst_cnt, e[CNT_W:1]);
    check({tag, "_stray"}, stray, e[0]);
  endtask

  task automatic drive_cycle(input string tag, input logic [1:0] r, input logic [1:0] s);
    @(negedge clk);
    req  = r;
    step = s;
    @(posedge clk);
    model_edge(r, s);
    #1;
    compare_outputs(tag);
  endtask

  // Reset is asserted mid-cycle so the outputs must clear with no clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req   = 2'b00;
    step  = 2'b00;
    #1;
    model_reset();
    exp_q.push_back(model_vec());
    compare_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset("rst0");

    // Single requester stepping every cycle, then voluntary release.
    for (int k = 0; k < 3; k++) drive_cycle("solo", 2'b01, 2'b01);
    for (int k = 0; k < 2; k++) drive_cycle("solo_rel", 2'b00, 2'b00);

    // Both requesting and stepping: burst exhaustion and direct handover.
    do_reset("rst1");
    for (int k = 0; k < 14; k++) drive_cycle("tie_burst", 2'b11, 2'b11);

    // Stray step from the non-owner while requester 0 holds the grant.
    do_reset("rst2");
    drive_cycle("stray_gnt", 2'b01, 2'b00);
    drive_cycle("stray_hit", 2'b01, 2'b10);
    drive_cycle("stray_after", 2'b01, 2'b00);

    // Step on the same cycle req drops, then the next tie goes to requester 1.
    drive_cycle("drop_step", 2'b00, 2'b01);
    drive_cycle("drop_tie", 2'b11, 2'b00);
    drive_cycle("drop_hold", 2'b11, 2'b00);

    // Build up burst_cnt=2 with the pair at 1, then reset mid-burst.
    do_reset("rst3");
    drive_cycle("mid_a", 2'b01, 2'b00);
    drive_cycle("mid_b", 2'b01, 2'b01);
    drive_cycle("mid_c", 2'b00, 2'b00);
    drive_cycle("mid_d", 2'b01, 2'b00);
    drive_cycle("mid_e", 2'b01, 2'b01);
    drive_cycle("mid_f", 2'b01, 2'b01);
    do_reset("rst_mid");
    drive_cycle("post_tie", 2'b11, 2'b00);

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rst_rand");
      else drive_cycle("rand", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
